conv2d_host_ctrl: RTL and testbench

Host-side sequencer for the conv2d accelerator's 16-word control memory. It accepts one layer descriptor per command and writes PARAM1, PARAM2, the nine kernel words and the CTRL start word into the control BRAM through the second port. It then polls CTRL for the done flag, clears it, and reports completion. It is the writer/poller counterpart of the accelerator's control-memory reader.

---
 rtl/conv2d_host_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_conv2d_host_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2d_host_ctrl.sv
// conv2d_host_ctrl: writes a layer descriptor into the conv2d control BRAM, starts it, polls CTRL for done.
// Optional poll timeout abort is enabled by defining CONV2D_POLL_TIMEOUT_EN.
module conv2d_host_ctrl #(
    parameter int unsigned POLL_GAP  = 15,
    parameter int unsigned MAX_POLLS = 65535
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_cmd_valid,
    output logic         o_cmd_ready,
    input  logic [7:0]   i_width,
    input  logic [7:0]   i_height,
    input  logic [1:0]   i_kernel_sz,
    input  logic         i_pad,
    input  logic [1:0]   i_stride,
    input  logic [9:0]   i_ci,
    input  logic [9:0]   i_co,
    input  logic [3:0]   i_layer,
    input  logic [143:0] i_kernel,
    output logic [3:0]   o_mem_addr,
    output logic         o_mem_we,
    output logic [31:0]  o_mem_wdata,
    input  logic [31:0]  i_mem_rdata,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_error
);
    typedef enum logic [3:0] {
        S_IDLE, S_WR_P1, S_WR_P2, S_WR_K, S_WR_CTRL, S_WAIT, S_POLL_RD, S_POLL_CHK, S_CLR
    } state_e;

    // a zero gap skips WAIT entirely
    localparam state_e POLL_NEXT = (POLL_GAP == 0) ? S_POLL_RD : S_WAIT;

    state_e         state_q, state_d;
    logic [3:0]     k_q, k_d;
    logic [7:0]     gap_q, gap_d;
    logic [7:0]     width_q, width_d, height_q, height_d;
    logic [1:0]     ksz_q, ksz_d, stride_q, stride_d;
    logic           pad_q, pad_d;
    logic [9:0]     ci_q, ci_d, co_q, co_d;
    logic [3:0]     layer_q, layer_d;
    logic [143:0]   kernel_q, kernel_d;
`ifdef CONV2D_POLL_TIMEOUT_EN
    logic [15:0]    polls_q, polls_d;
    logic           err_q, err_d;
    logic [30:0]    rdata_unused;
    assign rdata_unused = {i_mem_rdata[31:2], i_mem_rdata[0]};
`else
    logic [62:0]    rdata_unused;
    assign rdata_unused = {i_mem_rdata[31:2], i_mem_rdata[0], MAX_POLLS};
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= S_IDLE;
            k_q      <= '0;
            gap_q    <= '0;
            width_q  <= '0;
            height_q <= '0;
            ksz_q    <= '0;
            stride_q <= '0;
            pad_q    <= 1'b0;
            ci_q     <= '0;
            co_q     <= '0;
            layer_q  <= '0;
            kernel_q <= '0;
`ifdef CONV2D_POLL_TIMEOUT_EN
            polls_q  <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            gap_q    <= gap_d;
            width_q  <= width_d;
            height_q <= height_d;
            ksz_q    <= ksz_d;
            stride_q <= stride_d;
            pad_q    <= pad_d;
            ci_q     <= ci_d;
            co_q     <= co_d;
            layer_q  <= layer_d;
            kernel_q <= kernel_d;
`ifdef CONV2D_POLL_TIMEOUT_EN
            polls_q  <= polls_d;
            err_q    <= err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        gap_d       = gap_q;
        width_d     = width_q;
        height_d    = height_q;
        ksz_d       = ksz_q;
        stride_d    = stride_q;
        pad_d       = pad_q;
        ci_d        = ci_q;
        co_d        = co_q;
        layer_d     = layer_q;
        kernel_d    = kernel_q;
`ifdef CONV2D_POLL_TIMEOUT_EN
        polls_d     = polls_q;
        err_d       = err_q;
        o_error     = 1'b0;
`endif
        o_cmd_ready = 1'b0;
        o_mem_addr  = '0;
        o_mem_we    = 1'b0;
        o_mem_wdata = '0;
        o_done      = 1'b0;
        case (state_q)
            S_IDLE: begin
                o_cmd_ready = 1'b1;
                if (i_cmd_valid) begin
                    width_d  = i_width;
                    height_d = i_height;
                    ksz_d    = i_kernel_sz;
                    stride_d = i_stride;
                    pad_d    = i_pad;
                    ci_d     = i_ci;
                    co_d     = i_co;
                    layer_d  = i_layer;
                    kernel_d = i_kernel;
                    k_d      = '0;
`ifdef CONV2D_POLL_TIMEOUT_EN
                    polls_d  = '0;
                    err_d    = 1'b0;
`endif
                    state_d  = S_WR_P1;
                end
            end
            S_WR_P1: begin
                o_mem_addr  = 4'd2;
                o_mem_we    = 1'b1;
                o_mem_wdata = {11'b0, stride_q, pad_q, ksz_q, height_q, width_q};
                state_d     = S_WR_P2;
            end
            S_WR_P2: begin
                o_mem_addr  = 4'd3;
                o_mem_we    = 1'b1;
                o_mem_wdata = {12'b0, co_q, ci_q};
                state_d     = S_WR_K;
            end
            S_WR_K: begin
                o_mem_addr  = 4'd4 + k_q;
                o_mem_we    = 1'b1;
                o_mem_wdata = {16'b0, kernel_q[{k_q, 4'b0} +: 16]};
                k_d         = (k_q == 4'd8) ? 4'd0 : k_q + 4'd1;
                state_d     = (k_q == 4'd8) ? S_WR_CTRL : S_WR_K;
            end
            S_WR_CTRL: begin
                o_mem_we    = 1'b1;
                o_mem_wdata = {23'b0, layer_q, 5'b00101};
                gap_d       = '0;
                state_d     = POLL_NEXT;
            end
            S_WAIT: begin
                gap_d   = (gap_q + 8'd1 == 8'(POLL_GAP)) ? 8'd0 : gap_q + 8'd1;
                state_d = (gap_q + 8'd1 == 8'(POLL_GAP)) ? S_POLL_RD : S_WAIT;
            end
            S_POLL_RD: begin
`ifdef CONV2D_POLL_TIMEOUT_EN
                polls_d = polls_q + 16'd1;
`endif
                state_d = S_POLL_CHK;
            end
            S_POLL_CHK: begin
                state_d = i_mem_rdata[1] ? S_CLR : POLL_NEXT;
`ifdef CONV2D_POLL_TIMEOUT_EN
                if (!i_mem_rdata[1] && polls_q == 16'(MAX_POLLS)) begin
                    err_d   = 1'b1;
                    state_d = S_CLR;
                end
`endif
            end
            S_CLR: begin
                o_mem_we = 1'b1;
                o_done   = 1'b1;
`ifdef CONV2D_POLL_TIMEOUT_EN
                o_error  = err_q;
`endif
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifndef CONV2D_POLL_TIMEOUT_EN
    assign o_error = 1'b0;
`endif
    assign o_busy = (state_q != S_IDLE);
endmodule

// File: tb/tb_conv2d_host_ctrl.sv
// tb_conv2d_host_ctrl: randomized descriptors against a control-map model and a behavioural BRAM/accelerator model.
// Define CONV2D_POLL_TIMEOUT_EN to also exercise the timeout abort.
module tb_conv2d_host_ctrl;
    localparam int GAP  = 3;
    localparam int MAXP = 4;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_cmd_valid = 1'b0;
    logic         o_cmd_ready;
    logic [7:0]   i_width = '0;
    logic [7:0]   i_height = '0;
    logic [1:0]   i_kernel_sz = '0;
    logic         i_pad = 1'b0;
    logic [1:0]   i_stride = '0;
    logic [9:0]   i_ci = '0;
    logic [9:0]   i_co = '0;
    logic [3:0]   i_layer = '0;
    logic [143:0] i_kernel = '0;
    logic [3:0]   o_mem_addr;
    logic         o_mem_we;
    logic [31:0]  o_mem_wdata;
    logic [31:0]  i_mem_rdata = '0;
    logic         o_busy;
    logic         o_done;
    logic         o_error;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int set_at = -1;
    int clr_at = -1;
    logic [31:0] mem [16] = '{default: 32'h0};

    always #5 i_clk = ~i_clk;

    conv2d_host_ctrl #(.POLL_GAP(GAP), .MAX_POLLS(MAXP)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_width(i_width), .i_height(i_height), .i_kernel_sz(i_kernel_sz), .i_pad(i_pad),
        .i_stride(i_stride), .i_ci(i_ci), .i_co(i_co), .i_layer(i_layer), .i_kernel(i_kernel),
        .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(i_mem_rdata), .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
    );

    // BRAM with registered read; the accelerator side clears start / sets done at chosen cycles
    always @(posedge i_clk) begin
        cyc <= cyc + 1;
        i_mem_rdata <= mem[o_mem_addr];
        if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
        if (cyc == clr_at) mem[0][0] <= 1'b0;
        if (cyc == set_at) mem[0][1] <= 1'b1;
    end

    task automatic scramble();
        i_width = 8'($urandom);
        i_height = 8'($urandom);
        i_kernel_sz = 2'($urandom);
        i_pad = 1'($urandom);
        i_stride = 2'($urandom);
        i_ci = 10'($urandom);
        i_co = 10'($urandom);
        i_layer = 4'($urandom);
        for (int k = 0; k < 9; k++) i_kernel[16*k +: 16] = 16'($urandom);
    endtask

    // set_off < 0: done never set; clr_off > 0: start bit cleared that many cycles after the CTRL write
    task automatic run_cmd(input logic [7:0] w, input logic [7:0] h, input logic [1:0] ksz,
                           input logic pad, input logic [1:0] st, input logic [9:0] ci,
                           input logic [9:0] co, input logic [3:0] layer, input logic [143:0] kern,
                           input int set_off, input int clr_off);
        logic [3:0]  wa [12];
        logic [31:0] wd [12];
        logic [40:0] got, want;
        logic        wr, eerr;
        int t, p0, n, dd;
        wa[0] = 4'd2;
        wd[0] = 32'(st) * (1 << 19) + 32'(pad) * (1 << 18) + 32'(ksz) * (1 << 16) + 32'(h) * 256 + 32'(w);
        wa[1] = 4'd3;
        wd[1] = 32'(co) * 1024 + 32'(ci);
        for (int k = 0; k < 9; k++) begin
            wa[2+k] = 4'(4 + k);
            wd[2+k] = 32'(kern[16*k +: 16]);
        end
        wa[11] = 4'd0;
        wd[11] = 32'(layer) * 32 + 32'd4 + 32'd1;
        total++;
        if (o_cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL accept_ready: got %b want 1", o_cmd_ready);
        end
        t = cyc;
        set_at = (set_off < 0) ? -1 : t + 12 + set_off;
        clr_at = (clr_off > 0) ? t + 12 + clr_off : -1;
        i_width = w; i_height = h; i_kernel_sz = ksz; i_pad = pad; i_stride = st;
        i_ci = ci; i_co = co; i_layer = layer; i_kernel = kern;
        i_cmd_valid = 1'b1;
        @(negedge i_clk);
        i_cmd_valid = 1'b0;
        scramble();
        // polls read at p0, p0+GAP+2, ...; a read sees done only if it was set on an earlier edge
        p0 = t + 13 + GAP;
        n = (set_off < 0) ? 1000 : ((set_at + 1 <= p0) ? 0 : (set_at + 1 - p0 + GAP + 1) / (GAP + 2));
        eerr = 1'b0;
`ifdef CONV2D_POLL_TIMEOUT_EN
        if (n >= MAXP) begin
            n = MAXP - 1;
            eerr = 1'b1;
        end
`endif
        dd = p0 + (GAP + 2) * n + 2;
        for (int c = t + 1; c <= dd; c++) begin
            wr = (c <= t + 12);
            got  = {o_mem_we, o_mem_addr, o_mem_wdata, o_done, o_busy, o_cmd_ready, o_error};
            want = {wr || c == dd, wr ? wa[c-t-1] : 4'd0, wr ? wd[c-t-1] : 32'd0,
                    c == dd, 1'b1, 1'b0, eerr && c == dd};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL cycle T+%0d: got we/addr/data/done/busy/rdy/err=%b/%0d/%h/%b/%b/%b/%b want %b/%0d/%h/%b/%b/%b/%b",
                         c - t, got[40], got[39:36], got[35:4], got[3], got[2], got[1], got[0],
                         want[40], want[39:36], want[35:4], want[3], want[2], want[1], want[0]);
            end
            @(negedge i_clk);
        end
        set_at = -1;
        clr_at = -1;
        total++;
        if ({o_cmd_ready, o_busy, o_done, o_mem_we} !== 4'b1000) begin
            bad++;
            $display("FAIL back_to_idle: got rdy/busy/done/we=%b want 1000", {o_cmd_ready, o_busy, o_done, o_mem_we});
        end
        total++;
        if ({mem[2], mem[3], mem[12]} !== {wd[0], wd[1], wd[10]}) begin
            bad++;
            $display("FAIL mem_contents: got %h %h %h want %h %h %h", mem[2], mem[3], mem[12], wd[0], wd[1], wd[10]);
        end
    endtask

    task automatic rand_cmd(input int set_off, input int clr_off);
        logic [143:0] kern;
        for (int k = 0; k < 9; k++) kern[16*k +: 16] = 16'($urandom);
        run_cmd(8'($urandom), 8'($urandom), 2'($urandom), 1'($urandom), 2'($urandom),
                10'($urandom), 10'($urandom), 4'($urandom), kern, set_off, clr_off);
    endtask

    task automatic test_reset();
        #1 i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
        total++;
        if ({o_cmd_ready, o_busy, o_mem_we, o_mem_addr, o_mem_wdata, o_done, o_error} !== {1'b1, 40'b0}) begin
            bad++;
            $display("FAIL reset_outputs: got rdy=%b busy=%b we=%b addr=%0d data=%h done=%b err=%b want 1 0 0 0 0 0 0",
                     o_cmd_ready, o_busy, o_mem_we, o_mem_addr, o_mem_wdata, o_done, o_error);
        end
        i_rst = 1'b1;
        repeat (3) begin
            @(negedge i_clk);
            total++;
            if ({o_cmd_ready, o_busy, o_mem_we, o_done} !== 4'b1000) begin
                bad++;
                $display("FAIL idle_no_cmd: got rdy/busy/we/done=%b want 1000", {o_cmd_ready, o_busy, o_mem_we, o_done});
            end
        end
    endtask

    task automatic test_directed();
        logic [143:0] kern;
        for (int k = 0; k < 9; k++) kern[16*k +: 16] = 16'(k + 1);
        // done set 100 cycles after accept
        run_cmd(8'h20, 8'h20, 2'd3, 1'b0, 2'd1, 10'd3, 10'd16, 4'd2, kern, 88, 0);
        total++;
        if ({mem[2], mem[3]} !== {32'h000B2020, 32'h00004003}) begin
            bad++;
            $display("FAIL directed_params: got %h %h want 000b2020 00004003", mem[2], mem[3]);
        end
    endtask

    task automatic test_start_clear();
        rand_cmd(30, 5);
        rand_cmd(12, 1);
    endtask

    task automatic test_random();
        int s;
        for (int i = 0; i < 8; i++) begin
            s = $urandom_range(1, 60);
            rand_cmd(s, ($urandom_range(0, 1) == 1) ? $urandom_range(1, s) : 0);
        end
    endtask

    task automatic test_back_to_back();
        rand_cmd(1, 0);
        rand_cmd(2, 0);
        rand_cmd(7, 0);
    endtask

    task automatic test_reset_mid();
        logic [15:0] w3, w4;
        w3 = 16'($urandom);
        w4 = mem[8][15:0] ^ 16'h1;
        scramble();
        i_kernel[16*3 +: 16] = w3;
        i_kernel[16*4 +: 16] = w4;
        i_cmd_valid = 1'b1;
        @(negedge i_clk);
        i_cmd_valid = 1'b0;
        repeat (6) @(negedge i_clk);
        total++;
        if ({o_mem_we, o_mem_addr} !== {1'b1, 4'd8}) begin
            bad++;
            $display("FAIL mid_k4_write: got we=%b addr=%0d want 1 8", o_mem_we, o_mem_addr);
        end
        i_rst = 1'b0;
        #1;
        total++;
        if ({o_mem_we, o_mem_addr, o_mem_wdata, o_busy, o_cmd_ready} !== {38'b0, 1'b1}) begin
            bad++;
            $display("FAIL mid_reset_abort: got we=%b addr=%0d data=%h busy=%b rdy=%b want 0 0 0 0 1",
                     o_mem_we, o_mem_addr, o_mem_wdata, o_busy, o_cmd_ready);
        end
        @(negedge i_clk);
        i_rst = 1'b1;
        repeat (3) begin
            @(negedge i_clk);
            total++;
            if ({o_cmd_ready, o_busy, o_mem_we} !== 3'b100) begin
                bad++;
                $display("FAIL post_reset_idle: got rdy/busy/we=%b want 100", {o_cmd_ready, o_busy, o_mem_we});
            end
        end
        total++;
        if (mem[7][15:0] !== w3 || mem[8][15:0] === w4) begin
            bad++;
            $display("FAIL mid_reset_mem: got k3=%h k4=%h want k3=%h k4!=%h", mem[7][15:0], mem[8][15:0], w3, w4);
        end
    endtask

`ifdef CONV2D_POLL_TIMEOUT_EN
    task automatic test_timeout();
        rand_cmd(-1, 0);
        rand_cmd(-1, 3);
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_start_clear();
        test_random();
        test_back_to_back();
        test_reset_mid();
`ifdef CONV2D_POLL_TIMEOUT_EN
        test_timeout();
`endif
        rand_cmd(4, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
